// File: rtl/axi_st_csr_avmm_initiator.sv
// Avalon-MM initiator for the AXIST CSR: one write, read or poll-until-match per command.
// Ports: cmd_* request in, rsp_* response out, avm_* to/from the CSR master port, busy status.
module axi_st_csr_avmm_initiator #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int POLL_GAP       = 16,
  parameter int MAX_POLLS      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [15:0] rsp_polls,
  output logic        busy,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WRDONE, S_WAIT, S_GAP, S_RESP
  } state_t;

  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] GP = 32'(POLL_GAP);
  localparam logic [15:0] MP = 16'(MAX_POLLS);

  state_t      state, state_n;
  logic [1:0]  op;
  logic [31:0] mask;
  logic [31:0] cnt;
  logic [15:0] polls;
  logic        op_wr, op_poll, match;

  assign op_wr     = (op == 2'b00);
  assign op_poll   = (op == 2'b10);
  // avm_writedata doubles as the poll's expected value
  assign match     = ((avm_readdata ^ avm_writedata) & mask) == '0;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_polls = polls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (cmd_valid) state_n = S_ISSUE;
      S_ISSUE:  state_n = op_wr ? S_WRDONE : S_WAIT;
      S_WRDONE: state_n = S_RESP;
      S_WAIT: begin
        // rdv wins over a coinciding timeout
        if (avm_readdatavalid) begin
          if (!op_poll || match || polls == MP)
            state_n = S_RESP;
          else
            state_n = S_GAP;
        end else if (cnt == TO) begin
          state_n = S_RESP;
        end
      end
      S_GAP:    if (cnt == GP) state_n = S_ISSUE;
      S_RESP:   if (rsp_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op            <= '0;
      mask          <= '0;
      cnt           <= '0;
      polls         <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      rsp_status    <= '0;
      rsp_rdata     <= '0;
    end else begin
      avm_write <= 1'b0;
      avm_read  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op            <= cmd_op;
            mask          <= cmd_mask;
            avm_address   <= cmd_addr;
            avm_writedata <= cmd_wdata;
            polls         <= '0;
            avm_write     <= (cmd_op == 2'b00);
            avm_read      <= (cmd_op != 2'b00);
          end
        end
        S_ISSUE: begin
          cnt <= 32'd1;
          if (!op_wr && polls != 16'hFFFF)
            polls <= polls + 16'd1;
        end
        S_WRDONE: begin
          rsp_status <= 2'b00;
          rsp_rdata  <= '0;
        end
        S_WAIT: begin
          if (avm_readdatavalid) begin
            rsp_rdata  <= avm_readdata;
            rsp_status <= (op_poll && !match) ? 2'b10 : 2'b00;
            cnt        <= 32'd1;
          end else if (cnt == TO) begin
            rsp_status <= 2'b01;
            rsp_rdata  <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == GP) avm_read <= 1'b1;
          else           cnt      <= cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
